// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - issue/write-back stage around an external combinational ALU
module alu_issue_wb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_rd,
  input  logic [1:0]       cmd_rs1,
  input  logic [1:0]       cmd_rs2,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             wb_valid,
  output logic [1:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_c,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rf_q [4];
  logic [WIDTH-1:0] rf_d [4];
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]       alu_sel_q, alu_sel_d;
  logic [1:0]       rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             wb_valid_q, wb_valid_d;
  logic             flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic [WIDTH-1:0] rs1_val, rs2_val;

  // R0 is never written, but reads are forced to zero regardless
  assign rs1_val  = (cmd_rs1 == 2'd0) ? '0 : rf_q[cmd_rs1];
  assign rs2_val  = (cmd_rs2 == 2'd0) ? '0 : rf_q[cmd_rs2];
  assign dbg_data = (dbg_addr == 2'd0) ? '0 : rf_q[dbg_addr];

  assign cmd_ready = (state_q == IDLE) && rst_n;

  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    rd_d       = rd_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = wb_valid_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          alu_a_d   = rs1_val;
          alu_b_d   = cmd_imm_en ? cmd_imm : rs2_val;
          alu_sel_d = cmd_op;
          rd_d      = cmd_rd;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        wb_data_d  = alu_result;
        flag_z_d   = alu_zero;
        flag_c_d   = alu_carry;
        wb_rd_d    = rd_q;
        wb_valid_d = 1'b1;
        state_d    = WB;
      end
      WB: begin
        if (wb_rd_q != 2'd0) rf_d[wb_rd_q] = wb_data_q;
        wb_valid_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        wb_valid_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rd_q       <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      rd_q       <= rd_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_sel  = alu_sel_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - directed self-checking bench for alu_issue_wb
module tb_alu_issue_wb;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3, OP_XOR = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_imm_en;
  logic [2:0] cmd_op, alu_sel;
  logic [1:0] cmd_rd, cmd_rs1, cmd_rs2, wb_rd, dbg_addr;
  logic [7:0] cmd_imm, alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic       alu_zero, alu_carry, wb_valid, flag_z, flag_c;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wb_pulses = 0;
  int acc_q[$];

  always #5 clk = ~clk;

  alu_issue_wb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_z(flag_z), .flag_c(flag_c),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference combinational ALU
  always_comb begin
    {alu_carry, alu_result} = {1'b0, alu_a};
    case (alu_sel)
      OP_ADD: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: {alu_carry, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND: {alu_carry, alu_result} = {1'b0, alu_a & alu_b};
      OP_OR:  {alu_carry, alu_result} = {1'b0, alu_a | alu_b};
      OP_XOR: {alu_carry, alu_result} = {1'b0, alu_a ^ alu_b};
      default: ;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  always @(posedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
    if (wb_valid) wb_pulses++;
  end

  task automatic run_cmd(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic ie, input logic [7:0] imm,
                         output logic rdy_exec, output logic vld_wb, output logic vld_after,
                         output logic rdy_after, output logic [7:0] data,
                         output logic z, output logic c, output logic [1:0] wrd);
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rdy_exec = cmd_ready;
    @(posedge clk); #1;
    vld_wb = wb_valid; data = wb_data; z = flag_z; c = flag_c; wrd = wb_rd;
    @(posedge clk); #1;
    vld_after = wb_valid; rdy_after = cmd_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = OP_XOR; cmd_rd = 2'd1; cmd_rs1 = 2'd0;
    cmd_rs2 = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 8'hAA; dbg_addr = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
    n_cmp++; if ({alu_a, alu_b, alu_sel} !== 19'd0) begin n_err++; $display("FAIL reset_alu: got %h %h %h expected 0", alu_a, alu_b, alu_sel); end
    n_cmp++; if ({wb_valid, wb_rd, wb_data, flag_z, flag_c} !== 13'd0) begin n_err++; $display("FAIL reset_wb: got %b %h %h %b %b expected 0", wb_valid, wb_rd, wb_data, flag_z, flag_c); end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      n_cmp++; if (dbg_data !== 8'h00) begin n_err++; $display("FAIL reset_rf%0d: got %h expected 00", i, dbg_data); end
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_load_imm();
    logic re, v1, v2, ra, z, c; logic [7:0] d; logic [1:0] wr;
    run_cmd(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, re, v1, v2, ra, d, z, c, wr);
    n_cmp++; if (re !== 1'b0) begin n_err++; $display("FAIL li_ready_exec: got %b expected 0", re); end
    n_cmp++; if ({v1, v2} !== 2'b10) begin n_err++; $display("FAIL li_wb_pulse: got %b%b expected 10", v1, v2); end
    n_cmp++; if ({d, z, c, wr} !== {8'h7F, 1'b0, 1'b0, 2'd1}) begin n_err++; $display("FAIL li_result: got d=%h z=%b c=%b rd=%0d expected d=7f z=0 c=0 rd=1", d, z, c, wr); end
    n_cmp++; if (ra !== 1'b1) begin n_err++; $display("FAIL li_ready_after: got %b expected 1", ra); end
    dbg_addr = 2'd1; #1;
    n_cmp++; if (dbg_data !== 8'h7F) begin n_err++; $display("FAIL li_r1: got %h expected 7f", dbg_data); end
  endtask

  task automatic test_add_overflow();
    logic re, v1, v2, ra, z, c; logic [7:0] d; logic [1:0] wr;
    run_cmd(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h55, re, v1, v2, ra, d, z, c, wr);
    run_cmd(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, re, v1, v2, ra, d, z, c, wr);
    run_cmd(OP_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h01, re, v1, v2, ra, d, z, c, wr);
    dbg_addr = 2'd3; #1;
    n_cmp++; if (dbg_data !== 8'h55) begin n_err++; $display("FAIL ovf_r3_pre: got %h expected 55", dbg_data); end
    run_cmd(OP_ADD, 2'd3, 2'd1, 2'd2, 1'b0, 8'hEE, re, v1, v2, ra, d, z, c, wr);
    n_cmp++; if ({v1, d, z, c} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin n_err++; $display("FAIL ovf_result: got v=%b d=%h z=%b c=%b expected v=1 d=00 z=1 c=1", v1, d, z, c); end
    dbg_addr = 2'd3; #1;
    n_cmp++; if (dbg_data !== 8'h00) begin n_err++; $display("FAIL ovf_r3: got %h expected 00", dbg_data); end
  endtask

  task automatic test_sub_borrow();
    logic re, v1, v2, ra, z, c; logic [7:0] d; logic [1:0] wr;
    run_cmd(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, re, v1, v2, ra, d, z, c, wr);
    run_cmd(OP_SUB, 2'd2, 2'd1, 2'd3, 1'b1, 8'h06, re, v1, v2, ra, d, z, c, wr);
    n_cmp++; if ({d, z, c} !== {8'hFF, 1'b0, 1'b1}) begin n_err++; $display("FAIL sub_result: got d=%h z=%b c=%b expected d=ff z=0 c=1", d, z, c); end
    dbg_addr = 2'd2; #1;
    n_cmp++; if (dbg_data !== 8'hFF) begin n_err++; $display("FAIL sub_r2: got %h expected ff", dbg_data); end
    run_cmd(OP_AND, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00, re, v1, v2, ra, d, z, c, wr);
    n_cmp++; if ({d, z, c} !== {8'h05, 1'b0, 1'b0}) begin n_err++; $display("FAIL and_result: got d=%h z=%b c=%b expected d=05 z=0 c=0", d, z, c); end
  endtask

  task automatic test_r0_dest();
    logic re, v1, v2, ra, z, c; logic [7:0] d; logic [1:0] wr;
    run_cmd(OP_XOR, 2'd0, 2'd1, 2'd1, 1'b0, 8'h00, re, v1, v2, ra, d, z, c, wr);
    n_cmp++; if ({v1, d, z, c, wr} !== {1'b1, 8'h00, 1'b1, 1'b0, 2'd0}) begin n_err++; $display("FAIL r0_result: got v=%b d=%h z=%b c=%b rd=%0d expected v=1 d=00 z=1 c=0 rd=0", v1, d, z, c, wr); end
    run_cmd(OP_SUB, 2'd0, 2'd0, 2'd0, 1'b1, 8'h01, re, v1, v2, ra, d, z, c, wr);
    n_cmp++; if ({d, c} !== {8'hFF, 1'b1}) begin n_err++; $display("FAIL r0_sub: got d=%h c=%b expected d=ff c=1", d, c); end
    dbg_addr = 2'd0; #1;
    n_cmp++; if (dbg_data !== 8'h00) begin n_err++; $display("FAIL r0_read: got %h expected 00", dbg_data); end
  endtask

  task automatic test_back_to_back();
    int guard;
    acc_q.delete();
    cmd_op = OP_ADD; cmd_rd = 2'd1; cmd_rs1 = 2'd1; cmd_rs2 = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 8'h01;
    cmd_valid = 1'b1;
    guard = 0;
    while (acc_q.size() < 1 && guard < 10) begin @(posedge clk); #1; guard++; end
    cmd_rd = 2'd2; cmd_imm = 8'h10;
    guard = 0;
    while (acc_q.size() < 2 && guard < 10) begin @(posedge clk); #1; guard++; end
    cmd_valid = 1'b0;
    n_cmp++;
    if (acc_q.size() < 2) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 2", acc_q.size()); end
    else if (acc_q[1] - acc_q[0] !== 3) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 3", acc_q[1] - acc_q[0]); end
    guard = 0;
    while (!wb_valid && guard < 10) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 8'h16) begin n_err++; $display("FAIL b2b_result: got v=%b d=%h expected v=1 d=16", wb_valid, wb_data); end
    @(posedge clk); #1;
    dbg_addr = 2'd1; #1;
    n_cmp++; if (dbg_data !== 8'h06) begin n_err++; $display("FAIL b2b_r1: got %h expected 06", dbg_data); end
    dbg_addr = 2'd2; #1;
    n_cmp++; if (dbg_data !== 8'h16) begin n_err++; $display("FAIL b2b_r2: got %h expected 16", dbg_data); end
  endtask

  task automatic test_reset_exec();
    int pulses;
    cmd_op = OP_ADD; cmd_rd = 2'd3; cmd_rs1 = 2'd1; cmd_imm_en = 1'b1; cmd_imm = 8'h01;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rexec_ready_low: got %b expected 0", cmd_ready); end
    rst_n = 1'b1;
    pulses = wb_pulses;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (wb_pulses !== pulses) begin n_err++; $display("FAIL rexec_no_wb: got %0d pulses expected 0", wb_pulses - pulses); end
    n_cmp++; if ({flag_z, flag_c, wb_data, wb_rd} !== 12'd0) begin n_err++; $display("FAIL rexec_cleared: got z=%b c=%b d=%h rd=%0d expected 0", flag_z, flag_c, wb_data, wb_rd); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rexec_idle: got %b expected 1", cmd_ready); end
    for (int i = 1; i < 4; i++) begin
      dbg_addr = 2'(i); #1;
      n_cmp++; if (dbg_data !== 8'h00) begin n_err++; $display("FAIL rexec_r%0d: got %h expected 00", i, dbg_data); end
    end
  endtask

  initial begin
    test_reset();
    test_load_imm();
    test_add_overflow();
    test_sub_borrow();
    test_r0_dest();
    test_back_to_back();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Issue and write-back stage that wraps the 8-bit combinational ALU. It accepts one operation at a time over a valid/ready command port and reads operands from a 4-entry register file, with an optional immediate on operand B. It drives the ALU operand and select inputs, captures the ALU result and flags, and writes the result back to the register file. It also holds the architectural zero/carry flags and pulses a write-back strobe.

## Interface
- `WIDTH`, 8, datapath width; must match the ALU `WIDTH`.
- Register file depth is fixed at 4 (2-bit addresses); R0 reads as zero.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: stage can accept a command.
- `cmd_op` in 3: ALU select code, passed unmodified to `alu_sel`.
- `cmd_rd` in 2: destination register.
- `cmd_rs1` in 2: operand A source register.
- `cmd_rs2` in 2: operand B source register; ignored when `cmd_imm_en`=1.
- `cmd_imm_en` in 1: use `cmd_imm` as operand B.
- `cmd_imm` in WIDTH: immediate operand.
- `alu_a`, `alu_b` out WIDTH: registered operands to the ALU.
- `alu_sel` out 3: registered op to the ALU.
- `alu_result` in WIDTH: ALU result (combinational from `alu_*`).
- `alu_zero` in 1: ALU zero output.
- `alu_carry` in 1: ALU carry output.
- `wb_valid` out 1: one-cycle write-back strobe.
- `wb_rd` out 2: destination of the current write-back.
- `wb_data` out WIDTH: written value.
- `flag_z`, `flag_c` out 1: architectural flags.
- `dbg_addr` in 2: debug read address.
- `dbg_data` out WIDTH: combinational read of the register file; R0 returns 0.

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- `cmd_ready` = (state==IDLE) & `rst_n`. Command fields are sampled only on an edge where `cmd_valid` & `cmd_ready`.
- **IDLE, on accept:**
  - `alu_a` <= R[rs1].
  - `alu_b` <= `cmd_imm_en` ? `cmd_imm` : R[rs2].
  - `alu_sel` <= `cmd_op`; the destination is latched.
  - Next state is EXEC.
  - With no accept, all registers hold.
- **EXEC:**
  - The ALU evaluates combinationally from the held `alu_*`.
  - At the edge, capture `wb_data` <= `alu_result`, `flag_z` <= `alu_zero`, `flag_c` <= `alu_carry`; `wb_rd` <= latched rd.
  - `wb_valid` <= 1. Next state is WB.
- **WB:**
  - `wb_valid`=1 for exactly this cycle.
  - At the edge, R[wb_rd] <= `wb_data` unless `wb_rd`==0.
  - `wb_valid` <= 0. Next state is IDLE.
- **Flags:** updated on every operation, including writes to R0. `flag_c` takes the ALU carry verbatim: carry-out for ADD, bit WIDTH of the (WIDTH+1)-bit `a-b` for SUB, 0 for all other ops.
- **R0:** writes are discarded, reads return 0. `wb_valid`/`wb_data` still reflect the computed value.
- **Hazards:** none. A new command is accepted only after the WB edge has committed the register file, so the next command reads updated data.
- `alu_*`, `wb_rd`, `wb_data` hold their last values between operations.
- **Reset (any time, including mid-operation):**
  - State returns to IDLE and any in-flight operation is dropped; no `wb_valid` pulse.
  - R1..R3, `alu_a`, `alu_b`, `alu_sel`, `wb_valid`, `wb_rd`, `wb_data`, `flag_z`, `flag_c` are cleared to 0.
  - `cmd_ready`=0 while `rst_n` is low.

## Timing
- Reset values: every output 0. `dbg_data`=0 (all registers 0).
- Accept at edge N. The ALU sees the new operands during cycle N→N+1.
- `wb_valid`/`wb_data`/flags are visible after edge N+1.
- The register file is updated at edge N+2. `cmd_ready` is high again after edge N+2.
- Throughput is 1 command per 3 cycles. `cmd_ready` is low for exactly 2 cycles after each accept.
- `dbg_data` reflects a write-back in the cycle after edge N+2.

## Test plan
- **Reset:** hold `rst_n`=0 with `cmd_valid`=1 → `cmd_ready`=0, all outputs 0, no accept. After release, `cmd_ready`=1 in the first cycle.
- **Load immediate:** ADD rs1=0, imm=0x7F, rd=1 → `wb_valid` one cycle, `wb_data`=0x7F, Z=0, C=0; `dbg_data`(1)=0x7F.
- **ADD overflow:** R1=0xFF, R2=0x01; ADD rd=3 rs1=1 rs2=2 → `wb_data`=0x00, Z=1, C=1; R3=0x00.
- **SUB borrow:** R1=0x05, SUB imm=0x06 rd=2 → `wb_data`=0xFF, Z=0, C=1. Then AND → C=0.
- **R0 destination and back-to-back:**
  - XOR rs1=1 rs2=1 rd=0 → `wb_valid`=1, `wb_data`=0, Z=1, R0 still 0.
  - With `cmd_valid` held high across two commands, the second accept occurs exactly 3 cycles after the first and reads the first's result.
- **Reset during EXEC:** pulse `rst_n` low while in EXEC → no `wb_valid` pulse, flags=0, all registers 0, state IDLE.
